peak_histogram: RTL and testbench
=================================

PEAK_HISTOGRAM -- requirements
Module: peak_histogram

Interface
REQ-001 Parameter NP, default 16: timestamp and threshold width; matches `Np`.
REQ-002 Parameter NB, default 4: bin-index width; 2^NB bins; matches `Nb`.
REQ-003 Parameter CNT_W, default 12: per-bin counter width.
REQ-004 Port list, clock and reset first. One clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse; latches the window and starts a frame.
- frame_end  in  1  one-cycle pulse; closes accumulation.
- ts_valid  in  1  timestamp qualifier.
- ts  in  NP  TDC timestamp.
- th_minus  in  NP  window lower bound, inclusive.
- th_positive  in  NP  window upper bound, exclusive.
- bin_shift  in  $clog2(NP)  log2 of the bin width.
- peakCH  out  NB  index of the peak bin.
- peak_count  out  CNT_W  count held in the peak bin.
- peakDone  out  1  one-cycle pulse when peakCH is valid.
- busy  out  1  high in CLEAR, ACCUM and SCAN.

Function
REQ-005 FSM states: IDLE, CLEAR, ACCUM, SCAN, DONE.
REQ-006 IDLE or DONE + frame_start=1 -> CLEAR; th_minus, th_positive and bin_shift are latched on that edge.
REQ-007 CLEAR lasts exactly 1 cycle, zeroes all 2^NB counters, then goes to ACCUM.
REQ-008 In ACCUM, at most one event per cycle is accepted when ts_valid=1 and th_minus_q <= ts < th_positive_q.
REQ-009 Bin index = (ts - th_minus_q) >> bin_shift_q, unsigned NP-bit arithmetic; an event whose index >= 2^NB is discarded.
REQ-010 An accepted event increments its bin by 1 on the next edge.
REQ-011 Without the saturation feature (see REQ-020), counters wrap modulo 2^CNT_W.
REQ-012 ACCUM + frame_end=1 -> SCAN; an event valid in the same cycle as frame_end is counted.
REQ-013 SCAN visits bins 0 .. 2^NB-1, one per cycle, taking exactly 2^NB cycles.
REQ-014 The running maximum updates only on a strictly greater count, so a tie resolves to the lowest index; all bins zero gives peakCH=0, peak_count=0.
REQ-015 After the last bin: peakCH and peak_count are registered, peakDone=1 for exactly 1 cycle, state -> DONE.
- Latency from frame_end to peakDone = 2^NB + 1 cycles.
REQ-016 peakCH and peak_count hold their values until the next peakDone.
REQ-017 frame_start is ignored in CLEAR, ACCUM and SCAN; frame_end is ignored outside ACCUM.
REQ-018 ts_valid is ignored outside ACCUM.
REQ-019 DONE behaves as IDLE; frame_start in the DONE cycle starts a new frame.

Configuration
REQ-020 Macro PEAK_HIST_SATURATE_EN:
- defined: counters saturate at 2^CNT_W-1.
- undefined: counters wrap per REQ-011.

Reset
REQ-021 While rst_n=0 at a clock edge:
- state=IDLE, all counters 0, latched window 0;
- peakCH=0, peak_count=0, peakDone=0, busy=0.
REQ-022 Reset mid-frame or mid-scan aborts with no peakDone, and takes priority over every other input.

Structure
REQ-023 Package sifh_pkg holds NP/NB defaults, the FSM state enum, and the bin-count constant 2^NB.
REQ-024 Sub-module window_binner is combinational: in-window check plus index computation, outputting hit and bin index; the instantiating module registers the result.

Verification
REQ-025 Single bin: NP=16, NB=4; th_minus=100, th_positive=164, bin_shift=2; ts=121 x5 -> peakCH=5, peak_count=5, peakDone pulses 17 cycles after frame_end.
REQ-026 Window edges: ts=99, ts=164, ts=100 -> only ts=100 counts; peakCH=0, peak_count=1.
REQ-027 Tie: 3 events in bin 2 and 3 in bin 9 -> peakCH=2, peak_count=3.
REQ-028 Overflow: CNT_W=3, 9 events in bin 7 -> without macro peak_count=1 and peakCH=0; with macro peakCH=7 and peak_count=7.
REQ-029 Robustness: frame_start during SCAN is ignored and peakDone still arrives; rst_n=0 for 1 cycle mid-ACCUM gives no peakDone and all outputs 0.
REQ-030 Back-to-back frames: frame_start in the DONE cycle -> the second frame's histogram excludes all first-frame counts.

Source files
------------

// File: rtl/sifh_pkg.sv
// +----------------------------------------------------------------------+
// | sifh_pkg : shared defaults and FSM encoding for peak_histogram       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package sifh_pkg;

  localparam int c_NP_DEF    = 16;
  localparam int c_NB_DEF    = 4;
  localparam int c_NBINS_DEF = 1 << c_NB_DEF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/window_binner.sv
// +----------------------------------------------------------------------+
// | window_binner : combinational in-window test and bin-index compute   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module window_binner
  import sifh_pkg::*;
#(
  parameter int NP = c_NP_DEF,
  parameter int NB = c_NB_DEF,
  parameter int SW = $clog2(NP)
) (
  input  logic [NP-1:0] i_ts,
  input  logic [NP-1:0] i_thMinus,
  input  logic [NP-1:0] i_thPositive,
  input  logic [SW-1:0] i_binShift,
  output logic          o_hit,
  output logic [NB-1:0] o_binIdx
);

  logic [NP-1:0] w_offset;
  logic [NP-1:0] w_shifted;
  logic          w_inWindow;
  logic          w_inRange;

  assign w_inWindow = (i_ts >= i_thMinus) && (i_ts < i_thPositive);
  assign w_offset   = i_ts - i_thMinus;
  assign w_shifted  = w_offset >> i_binShift;
  // Any set bit above the index field means the event falls past the last bin.
  assign w_inRange  = ((w_shifted >> NB) == '0);
  assign o_hit      = w_inWindow && w_inRange;
  assign o_binIdx   = w_shifted[NB-1:0];

endmodule

`default_nettype wire

// File: rtl/peak_histogram.sv
// +----------------------------------------------------------------------+
// | peak_histogram : TDC timestamp histogram with peak-bin search        |
// | Option: define PEAK_HIST_SATURATE_EN to saturate bin counters        |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module peak_histogram
  import sifh_pkg::*;
#(
  parameter int NP    = c_NP_DEF,
  parameter int NB    = c_NB_DEF,
  parameter int CNT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    frame_end,
  input  logic                    ts_valid,
  input  logic [NP-1:0]           ts,
  input  logic [NP-1:0]           th_minus,
  input  logic [NP-1:0]           th_positive,
  input  logic [$clog2(NP)-1:0]   bin_shift,
  output logic [NB-1:0]           peakCH,
  output logic [CNT_W-1:0]        peak_count,
  output logic                    peakDone,
  output logic                    busy
);

  localparam int               c_SW       = $clog2(NP);
  localparam int               c_NBINS    = 1 << NB;
  localparam logic [NB-1:0]    c_LAST_BIN = '1;
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

  state_t           r_state;
  logic [NP-1:0]    r_thMinus;
  logic [NP-1:0]    r_thPositive;
  logic [c_SW-1:0]  r_binShift;
  logic [CNT_W-1:0] r_bins [c_NBINS];
  logic [NB-1:0]    r_scanIdx;
  logic [NB-1:0]    r_maxIdx;
  logic [CNT_W-1:0] r_maxCnt;
  logic [NB-1:0]    r_peakCH;
  logic [CNT_W-1:0] r_peakCount;
  logic             r_peakDone;
  logic             r_busy;

  logic             w_hit;
  logic [NB-1:0]    w_binIdx;
  logic             w_accept;
  logic [CNT_W-1:0] w_binCur;
  logic [CNT_W-1:0] w_binNext;
  logic [CNT_W-1:0] w_scanCnt;
  logic             w_scanGt;

  window_binner #(
    .NP (NP),
    .NB (NB),
    .SW (c_SW)
  ) u_binner (
    .i_ts         (ts),
    .i_thMinus    (r_thMinus),
    .i_thPositive (r_thPositive),
    .i_binShift   (r_binShift),
    .o_hit        (w_hit),
    .o_binIdx     (w_binIdx)
  );

  assign w_accept = (r_state == S_ACCUM) && ts_valid && w_hit;
  assign w_binCur = r_bins[w_binIdx];

`ifdef PEAK_HIST_SATURATE_EN
  assign w_binNext = (w_binCur == c_CNT_MAX) ? w_binCur : w_binCur + 1'b1;
`else
  assign w_binNext = w_binCur + 1'b1;
`endif

  // Strict compare keeps the earliest bin on ties.
  assign w_scanCnt = r_bins[r_scanIdx];
  assign w_scanGt  = (w_scanCnt > r_maxCnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_thMinus    <= '0;
      r_thPositive <= '0;
      r_binShift   <= '0;
      for (int i = 0; i < c_NBINS; i++) r_bins[i] <= '0;
      r_scanIdx    <= '0;
      r_maxIdx     <= '0;
      r_maxCnt     <= '0;
      r_peakCH     <= '0;
      r_peakCount  <= '0;
      r_peakDone   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_peakDone <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (frame_start) begin
            r_thMinus    <= th_minus;
            r_thPositive <= th_positive;
            r_binShift   <= bin_shift;
            r_busy       <= 1'b1;
            r_state      <= S_CLEAR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < c_NBINS; i++) r_bins[i] <= '0;
          r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (w_accept) r_bins[w_binIdx] <= w_binNext;
          if (frame_end) begin
            r_scanIdx <= '0;
            r_maxIdx  <= '0;
            r_maxCnt  <= '0;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_scanGt) begin
            r_maxCnt <= w_scanCnt;
            r_maxIdx <= r_scanIdx;
          end
          r_scanIdx <= r_scanIdx + 1'b1;
          if (r_scanIdx == c_LAST_BIN) begin
            r_peakCH    <= w_scanGt ? r_scanIdx : r_maxIdx;
            r_peakCount <= w_scanGt ? w_scanCnt : r_maxCnt;
            r_peakDone  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign peakCH     = r_peakCH;
  assign peak_count = r_peakCount;
  assign peakDone   = r_peakDone;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_peak_histogram.sv
// +----------------------------------------------------------------------+
// | tb_peak_histogram : directed self-checking bench for peak_histogram  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_peak_histogram;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        frame_end;
  logic        ts_valid;
  logic [15:0] ts;
  logic [15:0] th_minus;
  logic [15:0] th_positive;
  logic [3:0]  bin_shift;

  logic [3:0]  peakCH_a;
  logic [11:0] peakCount_a;
  logic        peakDone_a;
  logic        busy_a;

  logic [3:0]  peakCH_b;
  logic [2:0]  peakCount_b;
  logic        peakDone_b;
  logic        busy_b;

  int nChecks = 0;
  int nErrors = 0;

  peak_histogram #(.NP(16), .NB(4), .CNT_W(12)) u_dutA (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .ts_valid    (ts_valid),
    .ts          (ts),
    .th_minus    (th_minus),
    .th_positive (th_positive),
    .bin_shift   (bin_shift),
    .peakCH      (peakCH_a),
    .peak_count  (peakCount_a),
    .peakDone    (peakDone_a),
    .busy        (busy_a)
  );

  // Narrow-counter instance for the overflow vector.
  peak_histogram #(.NP(16), .NB(4), .CNT_W(3)) u_dutB (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .ts_valid    (ts_valid),
    .ts          (ts),
    .th_minus    (th_minus),
    .th_positive (th_positive),
    .bin_shift   (bin_shift),
    .peakCH      (peakCH_b),
    .peak_count  (peakCount_b),
    .peakDone    (peakDone_b),
    .busy        (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startFrame(input logic [15:0] lo, input logic [15:0] hi, input logic [3:0] sh);
    frame_start = 1'b1;
    th_minus    = lo;
    th_positive = hi;
    bin_shift   = sh;
    tick();
    frame_start = 1'b0;
    th_minus    = '0;
    th_positive = '0;
    bin_shift   = '0;
    tick();
  endtask

  task automatic sendTs(input logic [15:0] t);
    ts_valid = 1'b1;
    ts       = t;
    tick();
    ts_valid = 1'b0;
    ts       = '0;
  endtask

  // Leaves the bench in the cycle where peakDone is high (or at the bound).
  task automatic waitDone(input string tag, input int injectAt);
    int lat;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    lat = 1;
    while (!peakDone_a && lat < 60) begin
      frame_start = (lat == injectAt);
      th_minus    = 16'd7;
      th_positive = 16'd9;
      tick();
      frame_start = 1'b0;
      th_minus    = '0;
      th_positive = '0;
      lat++;
    end
    checkValue({tag, " latency"}, lat, 17);
    checkValue({tag, " busyDone"}, busy_a, 0);
  endtask

  initial begin
    int seen;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    ts_valid    = 1'b0;
    ts          = '0;
    th_minus    = '0;
    th_positive = '0;
    bin_shift   = '0;
    tick();
    tick();
    checkValue("rst peakCH", peakCH_a, 0);
    checkValue("rst count", peakCount_a, 0);
    checkValue("rst done", peakDone_a, 0);
    checkValue("rst busy", busy_a, 0);
    rst_n = 1'b1;
    tick();

    // (121-100)>>2 = 5
    frame_start = 1'b1; th_minus = 16'd100; th_positive = 16'd164; bin_shift = 4'd2;
    tick();
    frame_start = 1'b0;
    checkValue("single busyClear", busy_a, 1);
    tick();
    for (int i = 0; i < 5; i++) sendTs(16'd121);
    checkValue("single busyAccum", busy_a, 1);
    waitDone("single", 0);
    checkValue("single peakCH", peakCH_a, 5);
    checkValue("single count", peakCount_a, 5);
    tick();
    checkValue("single pulse", peakDone_a, 0);
    for (int i = 0; i < 4; i++) tick();
    checkValue("hold peakCH", peakCH_a, 5);
    checkValue("hold count", peakCount_a, 5);

    startFrame(16'd100, 16'd164, 4'd2);
    sendTs(16'd99);
    sendTs(16'd164);
    sendTs(16'd100);
    waitDone("edges", 0);
    checkValue("edges peakCH", peakCH_a, 0);
    checkValue("edges count", peakCount_a, 1);

    // Shift 0: offsets 16 and 20 fall past bin 15 and are dropped.
    startFrame(16'd0, 16'd1000, 4'd0);
    sendTs(16'd20);
    sendTs(16'd16);
    sendTs(16'd15);
    waitDone("idxRange", 0);
    checkValue("idxRange peakCH", peakCH_a, 15);
    checkValue("idxRange count", peakCount_a, 1);

    startFrame(16'd0, 16'd64, 4'd2);
    sendTs(16'd36); sendTs(16'd8); sendTs(16'd37);
    sendTs(16'd9);  sendTs(16'd38); sendTs(16'd10);
    waitDone("tie", 0);
    checkValue("tie peakCH", peakCH_a, 2);
    checkValue("tie count", peakCount_a, 3);

    startFrame(16'd0, 16'd64, 4'd2);
    sendTs(16'd4);
    sendTs(16'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkValue("midRst peakCH", peakCH_a, 0);
    checkValue("midRst count", peakCount_a, 0);
    checkValue("midRst busy", busy_a, 0);
    checkValue("midRst done", peakDone_a, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (peakDone_a) seen++;
      tick();
    end
    checkValue("midRst noDone", seen, 0);
    checkValue("idle endIgnored", busy_a, 0);

    startFrame(16'd0, 16'd64, 4'd2);
    sendTs(16'd4);
    sendTs(16'd5);
    waitDone("scanStart", 5);
    checkValue("scanStart peakCH", peakCH_a, 1);
    checkValue("scanStart count", peakCount_a, 2);

    startFrame(16'd100, 16'd164, 4'd2);
    sendTs(16'd120); sendTs(16'd121); sendTs(16'd122);
    waitDone("b2b first", 0);
    checkValue("b2b first peakCH", peakCH_a, 5);
    checkValue("b2b first count", peakCount_a, 3);
    startFrame(16'd100, 16'd164, 4'd2);
    sendTs(16'd104);
    waitDone("b2b second", 0);
    checkValue("b2b second peakCH", peakCH_a, 1);
    checkValue("b2b second count", peakCount_a, 1);

    // Nine hits in bin 7 plus one in bin 0; a wrapped bin 7 ties bin 0.
    startFrame(16'd0, 16'd64, 4'd2);
    for (int i = 0; i < 9; i++) sendTs(16'd28);
    sendTs(16'd0);
    waitDone("ovf", 0);
    checkValue("ovf wide peakCH", peakCH_a, 7);
    checkValue("ovf wide count", peakCount_a, 9);
    checkValue("ovf narrow done", peakDone_b, 1);
`ifdef PEAK_HIST_SATURATE_EN
    checkValue("ovf narrow peakCH", peakCH_b, 7);
    checkValue("ovf narrow count", peakCount_b, 7);
`else
    checkValue("ovf narrow peakCH", peakCH_b, 0);
    checkValue("ovf narrow count", peakCount_b, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire
